// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, drives instruction memory, and captures the returned word into IF/ID.
// It handles stall, redirect and bubbles, and latches a sticky fault on a misaligned or out-of-range fetch.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] fetch_count,
    output logic        fetch_fault
);

    localparam logic [31:0] LAST_PC = 32'(4 * MEM_WORDS - 4);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] count_q, count_d;
    logic        fault_q, fault_d;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        id_pc_d  = id_pc_q;
        id_pc4_d = id_pc4_q;
        count_d  = count_q;
        fault_d  = fault_q;

        case (state_q)
            RUN: begin
                if (redirect) begin
                    // The redirect squashes whatever is being fetched this cycle.
                    valid_d = 1'b0;
                    instr_d = 32'h0;
                    if ((redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_PC)) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (!stall) begin
                    valid_d  = 1'b1;
                    instr_d  = imem_instr;
                    id_pc_d  = pc_q;
                    id_pc4_d = pc_q + 32'd4;
                    count_d  = count_q + 32'd1;
                    // The last word is still delivered; only the advance past it faults.
                    if (pc_q == LAST_PC) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            FAULT: begin
                valid_d = 1'b0;
                instr_d = 32'h0;
            end
            default: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= 32'h0;
            id_pc_q  <= 32'h0;
            id_pc4_q <= 32'h0;
            count_q  <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            id_pc_q  <= id_pc_d;
            id_pc4_q <= id_pc4_d;
            count_q  <= count_d;
            fault_q  <= fault_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc       = id_pc_q;
    assign if_id_pc_plus4 = id_pc4_q;
    assign fetch_count    = count_q;
    assign fetch_fault    = fault_q;

endmodule
